// File: rtl/msx_wait_ctrl_pkg.sv
// Shared definitions for the MSX Z80 wait-state controller:
// FSM state encodings and default wait counts.
package msx_wait_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } wait_state_t;

  localparam int DEF_M1_WAITS = 1;
  localparam int DEF_IO_WAITS = 2;
  localparam int DEF_CNT_W    = 4;

endpackage

// File: rtl/msx_wait_counter.sv
// Saturating down-counter used to time the /WAIT low window.
// Loads a value, decrements on request and stops at zero.
module msx_wait_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && count != '0)
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/msx_wait_ctrl.sv
// Z80 /WAIT sequencer: inserts M1_WAITS waits per opcode fetch and, when
// MSX_WAIT_IO_EN is defined, IO_WAITS waits per I/O cycle.
module msx_wait_ctrl
  import msx_wait_ctrl_pkg::*;
#(
  parameter int M1_WAITS = DEF_M1_WAITS,
  parameter int IO_WAITS = DEF_IO_WAITS,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic n_m1,
  input  logic n_mreq,
  input  logic n_iorq,
  output logic n_wait,
  output logic busy
);

  if (M1_WAITS >= 2**CNT_W || IO_WAITS >= 2**CNT_W) begin : g_bad_cfg
    $error("msx_wait_ctrl: wait count does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] M1_N = CNT_W'(M1_WAITS);

  wait_state_t      state, state_nx;
  logic             n_wait_nx, busy_nx;
  logic             load, dec, cnt_zero;
  logic [CNT_W-1:0] sel_n;
  logic             trig_m1, trig_io;

  assign trig_m1 = !n_m1 && !n_mreq;

`ifdef MSX_WAIT_IO_EN
  localparam logic [CNT_W-1:0] IO_N = CNT_W'(IO_WAITS);
  assign trig_io = n_m1 && !n_iorq;
`else
  assign trig_io = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    n_wait_nx = 1'b1;
    load      = 1'b0;
    dec       = 1'b0;
    sel_n     = M1_N;
`ifdef MSX_WAIT_IO_EN
    if (!trig_m1) sel_n = IO_N;
`endif
    unique case (state)
      ST_IDLE: begin
        // Intack and plain memory cycles fall through both triggers.
        if (trig_m1 || trig_io) begin
          if (sel_n != '0) begin
            state_nx  = ST_WAIT;
            n_wait_nx = 1'b0;
            load      = 1'b1;
          end else begin
            state_nx  = ST_HOLD;
          end
        end
      end
      ST_WAIT: begin
        if (!cnt_zero) begin
          dec       = 1'b1;
          n_wait_nx = 1'b0;
        end else begin
          state_nx  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (n_mreq && n_iorq) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    busy_nx = (state_nx != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      n_wait <= 1'b1;
      busy   <= 1'b0;
    end else begin
      state  <= state_nx;
      n_wait <= n_wait_nx;
      busy   <= busy_nx;
    end
  end

  msx_wait_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (sel_n - 1'b1),
    .dec      (dec),
    .zero     (cnt_zero)
  );

endmodule

// File: tb/tb_msx_wait_ctrl.sv
// Bench for msx_wait_ctrl: three instances (M1_WAITS = 1, 3, 0) share one
// strobe stream and are compared against a countdown reference model.
module tb_msx_wait_ctrl;

`ifdef MSX_WAIT_IO_EN
  localparam bit IO_EN = 1'b1;
`else
  localparam bit IO_EN = 1'b0;
`endif
  localparam int IO_N = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic n_m1 = 1'b1, n_mreq = 1'b1, n_iorq = 1'b1;
  logic [2:0] nw, bz;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: engaged = inside a bus cycle that already got its insertion,
  // rem = wait periods still to run.
  bit eng [3];
  int rem [3];

  always #5 clk = ~clk;

  msx_wait_ctrl #(.M1_WAITS(1), .IO_WAITS(2), .CNT_W(4)) u_d0 (
    .clk(clk), .rst(rst), .n_m1(n_m1), .n_mreq(n_mreq), .n_iorq(n_iorq),
    .n_wait(nw[0]), .busy(bz[0]));
  msx_wait_ctrl #(.M1_WAITS(3), .IO_WAITS(2), .CNT_W(4)) u_d1 (
    .clk(clk), .rst(rst), .n_m1(n_m1), .n_mreq(n_mreq), .n_iorq(n_iorq),
    .n_wait(nw[1]), .busy(bz[1]));
  msx_wait_ctrl #(.M1_WAITS(0), .IO_WAITS(2), .CNT_W(4)) u_d2 (
    .clk(clk), .rst(rst), .n_m1(n_m1), .n_mreq(n_mreq), .n_iorq(n_iorq),
    .n_wait(nw[2]), .busy(bz[2]));

  function automatic int m1_n(input int i);
    case (i)
      0: return 1;
      1: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic exp_nw(input int i);
    return (eng[i] && rem[i] > 0) ? 1'b0 : 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin eng[i] = 1'b0; rem[i] = 0; end
  endtask

  // Advance one clock: update model from strobes seen at the edge.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        eng[i] = 1'b0; rem[i] = 0;
      end else if (eng[i] && rem[i] == 0) begin
        if (n_mreq && n_iorq) eng[i] = 1'b0;
      end else if (eng[i]) begin
        rem[i]--;
      end else if (!n_m1 && !n_mreq) begin
        eng[i] = 1'b1; rem[i] = m1_n(i);
      end else if (IO_EN && n_m1 && !n_iorq) begin
        eng[i] = 1'b1; rem[i] = IO_N;
      end
    end
    #1;
  endtask

  task automatic drive(input logic m1, input logic mreq, input logic iorq);
    n_m1 = m1; n_mreq = mreq; n_iorq = iorq;
  endtask

  task automatic test_reset();
    drive(1, 1, 1);
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (nw[i] !== 1'b1 || bz[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_state[%0d]: n_wait=%b busy=%b, required n_wait=1 busy=0", i, nw[i], bz[i]);
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_m1();
    int lows [3];
    for (int i = 0; i < 3; i++) lows[i] = 0;
    drive(0, 0, 1);
    repeat (5) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        if (nw[i] == 1'b0) lows[i]++;
        n_cmp++;
        if (nw[i] !== exp_nw(i) || bz[i] !== 1'b1) begin
          n_bad++;
          $display("FAIL m1_cycle[%0d]: n_wait=%b busy=%b, required n_wait=%b busy=1", i, nw[i], bz[i], exp_nw(i));
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (lows[i] != m1_n(i)) begin
        n_bad++;
        $display("FAIL m1_wait_len[%0d]: low for %0d clocks, required %0d", i, lows[i], m1_n(i));
      end
    end
    drive(1, 1, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (bz[i] !== 1'b0 || nw[i] !== 1'b1) begin
        n_bad++;
        $display("FAIL m1_release[%0d]: busy=%b n_wait=%b, required busy=0 n_wait=1", i, bz[i], nw[i]);
      end
    end
  endtask

  task automatic test_io();
    int lows [3];
    int want;
    want = IO_EN ? IO_N : 0;
    for (int i = 0; i < 3; i++) lows[i] = 0;
    drive(1, 1, 0);
    repeat (4) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        if (nw[i] == 1'b0) lows[i]++;
        n_cmp++;
        if (nw[i] !== exp_nw(i) || bz[i] !== IO_EN) begin
          n_bad++;
          $display("FAIL io_cycle[%0d]: n_wait=%b busy=%b, required n_wait=%b busy=%b", i, nw[i], bz[i], exp_nw(i), IO_EN);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (lows[i] != want) begin
        n_bad++;
        $display("FAIL io_wait_len[%0d]: low for %0d clocks, required %0d", i, lows[i], want);
      end
    end
    drive(1, 1, 1);
    tick();
  endtask

  task automatic test_intack();
    drive(0, 1, 0);
    repeat (3) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (nw[i] !== 1'b1 || bz[i] !== 1'b0) begin
          n_bad++;
          $display("FAIL intack[%0d]: n_wait=%b busy=%b, required n_wait=1 busy=0", i, nw[i], bz[i]);
        end
      end
    end
    drive(1, 1, 1);
    tick();
  endtask

  task automatic test_reset_mid_wait();
    int lows;
    drive(0, 0, 1);
    tick();
    tick();
    // u_d1 now has one wait period left after this one.
    #2 rst = 1'b1;
    drive(1, 1, 1);
    model_reset();
    #1;
    n_cmp++;
    if (nw[1] !== 1'b1 || bz[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_wait: n_wait=%b busy=%b, required n_wait=1 busy=0", nw[1], bz[1]);
    end
    #2 rst = 1'b0;
    tick();
    lows = 0;
    drive(0, 0, 1);
    repeat (5) begin
      tick();
      if (nw[1] == 1'b0) lows++;
      n_cmp++;
      if (nw[1] !== exp_nw(1)) begin
        n_bad++;
        $display("FAIL post_rst_m1: n_wait=%b, required %b", nw[1], exp_nw(1));
      end
    end
    n_cmp++;
    if (lows != 3) begin
      n_bad++;
      $display("FAIL post_rst_len: low for %0d clocks, required 3", lows);
    end
    drive(1, 1, 1);
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      // Bias towards idle strobes so cycles start and end often.
      drive(($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0));
      tick();
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (nw[i] !== exp_nw(i) || bz[i] !== eng[i]) begin
          n_bad++;
          $display("FAIL random[%0d] cyc %0d: n_wait=%b busy=%b, required n_wait=%b busy=%b", i, c, nw[i], bz[i], exp_nw(i), eng[i]);
        end
      end
    end
    drive(1, 1, 1);
    tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_m1();
    test_io();
    test_intack();
    test_reset_mid_wait();
    test_random();
    test_m1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
